// File: rtl/demo_pkg.sv
// Shared types and constants for the demo pattern sequencer.
// Holds the step-to-mode table and the scheduler state types.
package demo_pkg;

  localparam int NUM_STEPS = 8;

  // Entry [n] is the pattern mode for step n (step 0 = 1 ... step 7 = 6).
  localparam logic [NUM_STEPS-1:0][3:0] MODE_TABLE = {
    4'd6, 4'd7, 4'd4, 4'd2,
    4'd5, 4'd3, 4'd4, 4'd1
  };

  typedef enum logic {
    RST_HOLD,
    RUN
  } seq_state_t;

  typedef struct packed {
    logic [1:0] variant;
    logic [2:0] step;
    logic [2:0] depth;
  } sched_t;

  function automatic logic [3:0] mode_of(input logic [2:0] step);
    return MODE_TABLE[step];
  endfunction

endpackage

// File: rtl/demo_sequencer_frame_edge_det.sv
// Frame-start detector: active edge of vsync in either polarity.
// new_frame is combinational; frame_strobe is its registered copy.
module frame_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic vsync_pol,
  output logic new_frame,
  output logic frame_strobe
);

  logic prev_vsync;

  assign new_frame = (vsync == vsync_pol) &&
                     (prev_vsync != vsync_pol);

  // Remember last vsync and emit a one-cycle strobe per frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vsync   <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      prev_vsync   <= vsync;
      frame_strobe <= new_frame;
    end
  end

endmodule

// File: rtl/demo_sequencer.sv
// Demo sequencer: steps the pattern project through a mode/depth
// schedule, pulsing the project reset on every step change.
module demo_sequencer
  import demo_pkg::*;
#(
  parameter int DEPTH_FRAMES = 60,
  parameter int RST_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       vsync_pol,
  input  logic       manual_en,
  input  logic [3:0] manual_mode,
  input  logic [2:0] manual_depth,
  input  logic       hold,
  input  logic       skip,
  output logic [3:0] mode_out,
  output logic [2:0] depth_out,
  output logic [1:0] variant_out,
  output logic [2:0] step_out,
  output logic       proj_rst_n,
  output logic       frame_strobe
);

  localparam int FW =
    (DEPTH_FRAMES > 1) ? $clog2(DEPTH_FRAMES) : 1;
  localparam int HW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(DEPTH_FRAMES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(RST_CYCLES - 1);

  seq_state_t    state, state_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [FW-1:0] frame_cnt, frame_nx;
  sched_t        sch, sch_nx;

  logic new_frame;
  logic auto_run;
  logic ev_frame;
  logic bump_frame;
  logic bump_depth;
  logic bump_step;

  frame_edge_det u_edge (
    .clk          (clk),
    .rst          (rst),
    .vsync        (vsync),
    .vsync_pol    (vsync_pol),
    .new_frame    (new_frame),
    .frame_strobe (frame_strobe)
  );

  // Schedule events; skip pre-empts a coincident frame start.
  assign auto_run   = (state == RUN) && !manual_en && !hold;
  assign ev_frame   = auto_run && new_frame && !skip;
  assign bump_frame = ev_frame && (frame_cnt != F_LAST);
  assign bump_depth = ev_frame && (frame_cnt == F_LAST) &&
                      (sch.depth != 3'd7);
  assign bump_step  = (auto_run && skip) ||
                      (ev_frame && (frame_cnt == F_LAST) &&
                       (sch.depth == 3'd7));

  // State, hold counter and schedule registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_HOLD;
      hold_cnt  <= '0;
      frame_cnt <= '0;
      sch       <= '0;
    end else begin
      state     <= state_nx;
      hold_cnt  <= hold_nx;
      frame_cnt <= frame_nx;
      sch       <= sch_nx;
    end
  end

  // Next-state: reset-hold countdown, then frame/depth/step advance.
  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    frame_nx = frame_cnt;
    sch_nx   = sch;
    if (state == RST_HOLD) begin
      if (hold_cnt == H_LAST) begin
        state_nx = RUN;
        hold_nx  = '0;
      end else begin
        hold_nx = hold_cnt + 1'b1;
      end
    end else begin
      unique case (1'b1)
        bump_frame: frame_nx = frame_cnt + 1'b1;
        bump_depth: begin
          frame_nx     = '0;
          sch_nx.depth = sch.depth + 3'd1;
        end
        bump_step: begin
          frame_nx     = '0;
          sch_nx.depth = '0;
          sch_nx.step  = sch.step + 3'd1;
          if (sch.step == 3'd7)
            sch_nx.variant = sch.variant + 2'd1;
          state_nx = RST_HOLD;
          hold_nx  = '0;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs follow the next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_out    <= 4'b0001;
      depth_out   <= '0;
      variant_out <= '0;
      step_out    <= '0;
      proj_rst_n  <= 1'b0;
    end else begin
      mode_out    <= manual_en ? manual_mode
                               : mode_of(sch_nx.step);
      depth_out   <= manual_en ? manual_depth : sch_nx.depth;
      variant_out <= sch_nx.variant;
      step_out    <= sch_nx.step;
      proj_rst_n  <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_demo_sequencer.sv
// Directed bench for demo_sequencer.
// DEPTH_FRAMES=2, RST_CYCLES=4.
module tb_demo_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       vsync_pol;
  logic       manual_en;
  logic [3:0] manual_mode;
  logic [2:0] manual_depth;
  logic       hold;
  logic       skip;
  logic [3:0] mode_out;
  logic [2:0] depth_out;
  logic [1:0] variant_out;
  logic [2:0] step_out;
  logic       proj_rst_n;
  logic       frame_strobe;

  int n_cmp = 0;
  int n_err = 0;
  int strobes = 0;

  always #5 clk = ~clk;

  demo_sequencer #(
    .DEPTH_FRAMES (2),
    .RST_CYCLES   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vsync        (vsync),
    .vsync_pol    (vsync_pol),
    .manual_en    (manual_en),
    .manual_mode  (manual_mode),
    .manual_depth (manual_depth),
    .hold         (hold),
    .skip         (skip),
    .mode_out     (mode_out),
    .depth_out    (depth_out),
    .variant_out  (variant_out),
    .step_out     (step_out),
    .proj_rst_n   (proj_rst_n),
    .frame_strobe (frame_strobe)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vsync = vsync_pol;
    tick();
    if (frame_strobe) strobes++;
    vsync = ~vsync_pol;
    tick();
  endtask

  task automatic do_skip();
    skip = 1'b1;
    tick();
    skip = 1'b0;
    repeat (4) tick();
  endtask

  task automatic check_rst_vals(input string p);
    check({p, "_mode"}, 32'(mode_out), 32'd1);
    check({p, "_depth"}, 32'(depth_out), 32'd0);
    check({p, "_var"}, 32'(variant_out), 32'd0);
    check({p, "_step"}, 32'(step_out), 32'd0);
    check({p, "_prst"}, 32'(proj_rst_n), 32'd0);
    check({p, "_strb"}, 32'(frame_strobe), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    vsync        = 1'b0;
    vsync_pol    = 1'b1;
    manual_en    = 1'b0;
    manual_mode  = 4'd0;
    manual_depth = 3'd0;
    hold         = 1'b0;
    skip         = 1'b0;
    repeat (3) tick();
    check_rst_vals("rst");

    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rel_prst%0d", i),
            32'(proj_rst_n), 32'(i == 3));
    end
    check("rel_mode", 32'(mode_out), 32'd1);
    check("rel_depth", 32'(depth_out), 32'd0);

    strobes = 0;
    for (int f = 0; f < 15; f++) begin
      frame();
      check($sformatf("f%0d_depth", f),
            32'(depth_out), 32'((f + 1) / 2));
      check($sformatf("f%0d_step", f), 32'(step_out), 32'd0);
    end
    vsync = 1'b1;
    tick();
    if (frame_strobe) strobes++;
    check("f15_step", 32'(step_out), 32'd1);
    check("f15_mode", 32'(mode_out), 32'd4);
    check("f15_depth", 32'(depth_out), 32'd0);
    check("f15_prst", 32'(proj_rst_n), 32'd0);
    vsync = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("s1_prst%0d", i),
            32'(proj_rst_n), 32'(i == 3));
    end
    check("strobes16", 32'(strobes), 32'd16);

    for (int s = 2; s <= 6; s++) begin
      do_skip();
      check($sformatf("skip_step%0d", s), 32'(step_out), 32'(s));
    end
    check("s6_mode", 32'(mode_out), 32'd7);
    repeat (3) frame();
    check("s6_depth", 32'(depth_out), 32'd1);

    vsync = 1'b1;
    skip  = 1'b1;
    tick();
    check("coin_step", 32'(step_out), 32'd7);
    check("coin_mode", 32'(mode_out), 32'd6);
    check("coin_depth", 32'(depth_out), 32'd0);
    check("coin_strb", 32'(frame_strobe), 32'd1);
    skip  = 1'b0;
    vsync = 1'b0;
    repeat (4) tick();
    check("coin_prst", 32'(proj_rst_n), 32'd1);
    frame();
    check("uncounted_d0", 32'(depth_out), 32'd0);
    frame();
    check("uncounted_d1", 32'(depth_out), 32'd1);

    do_skip();
    check("wrap_step", 32'(step_out), 32'd0);
    check("wrap_var", 32'(variant_out), 32'd1);
    check("wrap_mode", 32'(mode_out), 32'd1);
    check("wrap_depth", 32'(depth_out), 32'd0);
    frame();

    manual_en    = 1'b1;
    manual_mode  = 4'd7;
    manual_depth = 3'd3;
    tick();
    check("man_mode0", 32'(mode_out), 32'd7);
    check("man_depth0", 32'(depth_out), 32'd3);
    skip = 1'b1;
    tick();
    skip = 1'b0;
    strobes = 0;
    repeat (10) frame();
    check("man_strobes", 32'(strobes), 32'd10);
    check("man_mode", 32'(mode_out), 32'd7);
    check("man_depth", 32'(depth_out), 32'd3);
    check("man_step", 32'(step_out), 32'd0);
    check("man_var", 32'(variant_out), 32'd1);
    check("man_prst", 32'(proj_rst_n), 32'd1);
    manual_en = 1'b0;
    tick();
    check("res_mode", 32'(mode_out), 32'd1);
    check("res_depth", 32'(depth_out), 32'd0);
    frame();
    check("res_depth1", 32'(depth_out), 32'd1);

    hold = 1'b1;
    skip = 1'b1;
    tick();
    skip = 1'b0;
    repeat (4) frame();
    check("hold_step", 32'(step_out), 32'd0);
    check("hold_depth", 32'(depth_out), 32'd1);
    check("hold_prst", 32'(proj_rst_n), 32'd1);
    hold = 1'b0;

    skip = 1'b1;
    tick();
    skip = 1'b0;
    check("mid_prst", 32'(proj_rst_n), 32'd0);
    check("mid_step", 32'(step_out), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check_rst_vals("midrst");
    rst = 1'b0;

    vsync_pol = 1'b0;
    vsync     = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    check("pol0_strb1", 32'(frame_strobe), 32'd1);
    tick();
    check("pol0_strb0", 32'(frame_strobe), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demo_sequencer.md
DEMO_SEQUENCER -- requirements
Module: demo_sequencer

Interface
REQ-001 SHALL have parameter DEPTH_FRAMES, default 60: frames per colour-depth sub-step, minimum 1.
REQ-002 SHALL have parameter RST_CYCLES, default 4: clocks the project reset is held low per step change, minimum 1.
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 vsync  in  1  raw vsync from the pattern project.
REQ-006 vsync_pol  in  1  active level of vsync; equals the mode bit 3 fed to the project.
REQ-007 manual_en  in  1  1 = manual override, 0 = automatic schedule.
REQ-008 manual_mode  in  4  mode used under override.
REQ-009 manual_depth  in  3  depth used under override.
REQ-010 hold  in  1  level; freezes the automatic schedule.
REQ-011 skip  in  1  single-cycle pulse; advance to the next step.
REQ-012 mode_out  out  4  pattern mode to the project (ui_in[7:4]).
REQ-013 depth_out  out  3  colour depth to the dither stage.
REQ-014 variant_out  out  2  sub-variant to the project (ui_in[3:2]).
REQ-015 step_out  out  3  current schedule step index.
REQ-016 proj_rst_n  out  1  active-low reset to the pattern project.
REQ-017 frame_strobe  out  1  one-cycle pulse per detected frame start.

Function
REQ-018 new_frame SHALL be true when vsync==vsync_pol and prev_vsync!=vsync_pol; prev_vsync is registered vsync.
REQ-019 frame_strobe SHALL assert the cycle after new_frame, for one cycle, in every state and mode.
REQ-020 FSM states SHALL be RST_HOLD and RUN.
REQ-021 RST_HOLD: proj_rst_n=0; hold counter counts RST_CYCLES clocks, then RUN; frames, skip and hold ignored.
REQ-022 RUN: proj_rst_n=1.
REQ-023 RUN, manual_en=0, hold=0, new_frame: frame_cnt increments.
REQ-024 At frame_cnt==DEPTH_FRAMES-1: frame_cnt->0 and depth increments.
REQ-025 When depth==7 also wraps: depth->0, step increments, state->RST_HOLD.
REQ-026 When step wraps 7->0, variant SHALL increment mod 4.
REQ-027 skip in RUN with manual_en=0 SHALL advance exactly like REQ-025 immediately, with frame_cnt->0.
REQ-028 skip SHALL take priority over a same-cycle new_frame; that frame is not counted.
REQ-029 hold=1 SHALL freeze frame_cnt, depth, step and variant; skip is ignored.
REQ-030 manual_en=1 SHALL freeze the schedule, ignore skip, and drive mode_out=manual_mode and depth_out=manual_depth.
REQ-031 manual_en 1->0 SHALL resume the schedule from the frozen position.
REQ-032 In automatic mode, mode_out SHALL be MODE_TABLE[step].
REQ-033 MODE_TABLE is {1,4,3,5,2,4,7,6} for steps 0..7.
REQ-034 In automatic mode, depth_out SHALL equal depth.
REQ-035 All outputs SHALL be registered, with one-cycle latency from the causing input or state change.
REQ-036 Counters SHALL be sized for their parameters and never overflow.

Reset
REQ-037 rst SHALL be honoured in any state, including mid-RST_HOLD and mid-frame.
REQ-038 rst SHALL set: state=RST_HOLD, hold counter 0, frame_cnt 0, depth 0, step 0, variant 0, prev_vsync 0.
REQ-039 Output reset values: mode_out=4'b0001, depth_out=0, variant_out=0, step_out=0, proj_rst_n=0, frame_strobe=0.

Structure
REQ-040 Package demo_pkg SHALL hold MODE_TABLE, the FSM state typedef and NUM_STEPS=8.
REQ-041 Frame-edge detection SHALL be a sub-module, frame_edge_det.

Verification
REQ-042 Bench parameters SHALL be DEPTH_FRAMES=2 and RST_CYCLES=4.
REQ-043 Release rst -> proj_rst_n low 4 cycles then high; mode_out=1, depth_out=0.
REQ-044 16 frames in RUN -> depth steps 0..7 every 2 frames; then step_out=1, mode_out=4, proj_rst_n low 4 cycles.
REQ-045 skip coincident with new_frame at step 6 -> step_out=7, mode_out=6, depth_out=0, frame not counted.
REQ-046 Full cycle of 8 steps -> step_out=0, variant_out=1, mode_out=1.
REQ-047 manual_en=1, manual_mode=7, manual_depth=3, 10 frames -> outputs 7/3, step and depth frozen, frame_strobe pulses 10 times.
REQ-048 hold=1 plus skip plus frames -> no change; rst asserted during RST_HOLD -> all REQ-039 values the next cycle.
